// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first, 8-bit frames. One chip-select window carries
// one or more bytes from a valid/ready byte stream; tx_last closes the window.
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       ar,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs
);

  localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_P);

  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW, ST_NEXT, ST_HOLD, ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       tx_sh_q, tx_sh_d;
  logic [6:0]       rx_sh_q, rx_sh_d;
  logic             last_q, last_d;
  logic             sck_q, sck_d;
  logic             cs_q, cs_d;
  logic             mosi_q, mosi_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             busy_q, busy_d;
  logic             tx_ready_q, tx_ready_d;
  logic             miso_s1_q, miso_s2_q;

  logic accept;
  logic cnt_zero;

  assign accept   = tx_valid && tx_ready_q;
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cs_d    = 1'b0;
          mosi_d  = tx_data[7];
          tx_sh_d = tx_data[6:0];
          last_d  = tx_last;
          bit_d   = 3'd0;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (cnt_zero) begin
          sck_d   = 1'b1;
          cnt_d   = DIV_LD;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          // Sample at the very end of the high phase to give the slave's
          // reply the longest possible settling time through the synchroniser.
          sck_d   = 1'b0;
          rx_sh_d = {rx_sh_q[5:0], miso_s2_q};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rx_valid_d = 1'b1;
            rx_data_d  = {rx_sh_q, miso_s2_q};
            cnt_d      = HOLD_LD;
            state_d    = last_q ? ST_HOLD : ST_NEXT;
          end else begin
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
            cnt_d   = DIV_LD;
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_NEXT: begin
        // Going through LOW guarantees a full low phase before the next rise.
        if (accept) begin
          mosi_d  = tx_data[7];
          tx_sh_d = tx_data[6:0];
          last_d  = tx_last;
          cnt_d   = DIV_LD;
          state_d = ST_LOW;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cs_d    = 1'b1;
          cnt_d   = IDLE_LD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_zero) state_d = ST_IDLE;
        else          cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d != ST_IDLE);
    tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_NEXT);
  end

  // NOTE: asynchronous active-low reset puts the pins in their safe state
  // without waiting for a clock edge; all flops update with <= only.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      tx_sh_q    <= 7'd0;
      rx_sh_q    <= 7'd0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      miso_s1_q  <= 1'b0;
      miso_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
      miso_s1_q  <= miso;
      miso_s2_q  <= miso_s1_q;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs       = cs_q;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Mode-0 SPI master (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Drives sck/mosi/cs into the team's SPI slave and captures its miso reply.
- Sits between an on-chip byte producer/consumer (valid/ready byte interface) and the SPI pins.
- One chip-select window carries one or more bytes; tx_last closes the window.

Parameters:
- CLK_DIV, 4: system clocks per sck half-period. Must be >= 4, because the slave oversamples sck/cs/mosi through 2-3 flop synchronisers.
- CS_SETUP, 4: clocks from cs falling to the first sck rising edge. Must be >= 4.
- CS_HOLD, 4: clocks from the last sck falling edge to cs rising.
- CS_IDLE, 4: minimum clocks cs stays high before the next transaction.

Ports:
- clk  in  1  system clock
- ar  in  1  reset, asynchronous, active-low
- tx_valid  in  1  byte offered
- tx_data  in  8  byte to transmit
- tx_last  in  1  qualifies tx_data; 1 = final byte of the cs window
- tx_ready  out  1  master accepts tx_data this cycle
- rx_valid  out  1  one-cycle pulse; rx_data holds the received byte
- rx_data  out  8  byte captured from miso
- busy  out  1  high in every state except IDLE
- sck  out  1  SPI clock
- mosi  out  1  SPI MOSI
- miso  in  1  SPI MISO (asynchronous; 2-flop synchronised internally)
- cs  out  1  SPI chip select, active low

Behaviour:
- One clock domain, clk. Reset ar is asynchronous, active-low.
- Reset values: state=IDLE, sck=0, cs=1, mosi=0, rx_valid=0, rx_data=0x00, busy=0, tx_ready=0. tx_ready rises on the first clock after reset release.
- Reset mid-transfer: pins return to reset values immediately (asynchronously); the partial byte is discarded and rx_valid is not pulsed.
- All outputs are registered. One shared down-counter times every phase, with width = clog2 of the max parameter.
- Handshake: a transfer is accepted on a clock where tx_valid && tx_ready. tx_data and tx_last are latched on that clock. tx_valid while tx_ready=0 is ignored (no buffering).
- States:
  - IDLE: tx_ready=1, cs=1, sck=0. On accept: cs<=0, mosi<=tx_data[7], goto SETUP.
  - SETUP: CS_SETUP clocks, sck=0. Then sck<=1 (rising edge), goto HIGH.
  - HIGH: CLK_DIV clocks, sck=1. On the last clock, shift synchronised miso into the rx shift register (LSB in).
    - If bits remain: sck<=0, mosi<=next bit, goto LOW.
    - After the 8th bit: sck<=0, rx_valid<=1, rx_data<=shift; goto NEXT if latched tx_last=0, else HOLD.
  - LOW: CLK_DIV clocks, sck=0. Then sck<=1, goto HIGH.
  - NEXT: cs stays 0, sck=0, tx_ready=1, waits indefinitely. On accept: mosi<=tx_data[7], goto LOW (gives a full CLK_DIV low phase before the rise).
  - HOLD: CS_HOLD clocks, cs=0. Then cs<=1, goto GAP.
  - GAP: CS_IDLE clocks, cs=1. Then goto IDLE.
- Per byte: exactly 8 rising edges, spaced 2*CLK_DIV clocks apart.
- mosi changes only on the sck falling edge or in SETUP/NEXT, so it is stable around every rise.
- miso is sampled at the end of HIGH, >= 2*CLK_DIV clocks after the slave's shift point. This covers slave latency (3 clocks) plus the 2-flop synchroniser.
- rx_valid pulse: the same clock the 8th-bit sck falls. It is not back-pressured; the consumer must take it.
- Bit counter wraps 7->0 per byte. No limit on the number of bytes per cs window.
- tx_ready is 0 in SETUP/HIGH/LOW/HOLD/GAP. An accept in NEXT with tx_last=1 makes that byte the final one.

Test Plan:
- Loopback (miso tied to mosi), CLK_DIV=4: send 0xA5 with last=1.
  - cs falls 1 clock after accept; first sck rise 4 clocks later; 8 rises, 8 clocks apart.
  - rx_valid pulses once with rx_data=0xA5; cs rises 4 clocks after the last sck fall; busy low 4 clocks later.
- Paired with the SPI slave model (returns message count at cs fall, zeros afterwards), reset, three single-byte transactions -> rx_data = 0x00, 0x01, 0x02.
- Multi-byte window: bytes 0x12, 0x34 (last on 2nd) to slave model -> cs low throughout; 16 sck rises; rx = 0x03, 0x00; one cs fall.
- Stall in NEXT: withhold tx_valid for 50 clocks after byte 1 -> sck stays 0, cs stays 0, tx_ready=1. Resuming with 0xFF/last=1 gives a full 4-clock low phase before the first rise.
- Assert ar low during bit 3 -> cs=1, sck=0, mosi=0 with no clock edge needed; no rx_valid. After release, a new 0x5A loopback returns 0x5A.
- tx_valid held high continuously with last=1 -> accepts exactly 1 byte per IDLE visit; GAP of 4 clocks with cs=1 between transactions.
